fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID buffer.
- Owns the PC and drives the instruction-memory (I-cache) read handshake.
- Produces the IF fields of the pipeline packet: data.pc and data.instruction, plus a valid bit.
- Absorbs downstream stalls with a one-entry skid buffer and handles branch/jump redirects, including redirects that arrive while a memory request is outstanding.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_skid_buffer.sv | 30 +++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0060;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } if_entry_t;

  // Instruction addresses are word aligned; low bits of a target are ignored.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry skid buffer holding a fetched instruction while the output slot is stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      drain,
  input  logic      clear,
  input  if_entry_t load_entry,
  output logic      valid,
  output if_entry_t entry
);

  // Clear (redirect flush) beats load, load beats drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: owns the PC, runs the I-cache read handshake, and feeds the IF/ID buffer.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] inst_mem_address,
  output logic            inst_mem_read,
  input  logic            inst_mem_resp,
  input  logic [XLEN-1:0] inst_mem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instruction
);

  fetch_state_t    state;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] next_pc;
  if_entry_t       out_slot;

  logic            consume;
  logic [XLEN-1:0] target;
  logic            skid_load;
  logic            skid_drain;
  logic            skid_clear;
  logic            skid_valid;
  if_entry_t       skid_entry;
  if_entry_t       fetched;

  always_comb begin
    consume    = if_valid && !stall;
    target     = align_pc(redirect_pc);
    fetched    = '{pc: req_addr, instruction: inst_mem_rdata};
    skid_clear = redirect;
    skid_load  = !redirect && (state == FETCH) && inst_mem_resp && if_valid && stall;
    skid_drain = !redirect && (state == HOLD) && consume;
  end

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_entry (fetched),
    .valid      (skid_valid),
    .entry      (skid_entry)
  );

  // The request line follows the registered state; reset forces it low immediately.
  assign inst_mem_read    = rst && (state != HOLD);
  assign inst_mem_address = req_addr;
  assign if_pc            = out_slot.pc;
  assign if_instruction   = out_slot.instruction;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      req_addr <= RESET_PC;
      next_pc  <= RESET_PC + PC_STEP;
      if_valid <= 1'b0;
      out_slot <= '0;
    end else if (redirect) begin
      // An outstanding request is never aborted: park the target until its response.
      if_valid <= 1'b0;
      if (state == HOLD || inst_mem_resp) begin
        req_addr <= target;
        next_pc  <= target + PC_STEP;
        state    <= FETCH;
      end else begin
        next_pc <= target;
        state   <= DISCARD;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (inst_mem_resp) begin
            req_addr <= next_pc;
            next_pc  <= next_pc + PC_STEP;
            if (!if_valid || consume) begin
              if_valid <= 1'b1;
              out_slot <= fetched;
            end else begin
              state <= HOLD;
            end
          end else if (consume) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (consume) begin
            out_slot <= skid_entry;
            state    <= FETCH;
          end
        end
        DISCARD: begin
          if (inst_mem_resp) begin
            req_addr <= next_pc;
            next_pc  <= next_pc + PC_STEP;
            state    <= FETCH;
          end
          if (consume) begin
            if_valid <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Entry and skid state only matter together; keep the skid flag observable.
  logic skid_unused;
  assign skid_unused = skid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: transaction-level model of the fetch stream plus a latency-varying memory.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] inst_mem_address;
  logic        inst_mem_read;
  logic        inst_mem_resp;
  logic [31:0] inst_mem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .inst_mem_address (inst_mem_address),
    .inst_mem_read    (inst_mem_read),
    .inst_mem_resp    (inst_mem_resp),
    .inst_mem_rdata   (inst_mem_rdata),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instruction   (if_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_addr;
  logic [31:0] pend_addr;
  bit          busy;
  bit          pend_stale;
  int          cnt;
  int          p_stall;
  int          p_redir;
  int          lat_max;
  bit          force_redir;
  logic [31:0] force_rpc;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_addr   = 32'h0000_0060;
    pend_addr  = 32'h0;
    busy       = 1'b0;
    pend_stale = 1'b0;
    cnt        = 0;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(3, 0))
      0:       return 32'hFFFF_FFFC;
      1:       return v & 32'h0000_0FFF;
      default: return v;
    endcase
  endfunction

  // One clock: check outputs against the model, play memory, drive inputs, advance the model.
  task automatic run_cycle();
    bit          s, r, rs;
    logic [31:0] rp, rd;
    @(negedge clk);
    check("if_valid", 32'(if_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("if_pc", if_pc, q[0].pc);
      check("if_instr", if_instruction, q[0].ins);
    end
    check("read", 32'(inst_mem_read), 32'(q.size() < 2));
    check("skid_inv", 32'(dut.u_skid.valid && !if_valid), 32'd0);

    rs = 1'b0;
    rd = $urandom;
    if (inst_mem_read) begin
      if (!busy) begin
        check("req_addr", inst_mem_address, exp_addr);
        busy       = 1'b1;
        pend_addr  = inst_mem_address;
        pend_stale = 1'b0;
        cnt        = $urandom_range(lat_max, 1);
      end else begin
        check("addr_stable", inst_mem_address, pend_addr);
        cnt--;
        if (cnt == 0) begin
          rs   = 1'b1;
          busy = 1'b0;
        end
      end
    end

    s  = ($urandom_range(99, 0) < p_stall);
    r  = force_redir || ($urandom_range(99, 0) < p_redir);
    rp = force_redir ? force_rpc : pick_target();
    force_redir = 1'b0;

    stall          = s;
    redirect       = r;
    redirect_pc    = rp;
    inst_mem_resp  = rs;
    inst_mem_rdata = rd;

    if (r) begin
      q.delete();
      exp_addr = {rp[31:2], 2'b00};
      if (busy) pend_stale = 1'b1;
    end else begin
      if (q.size() > 0 && !s) void'(q.pop_front());
      if (rs && !pend_stale) begin
        q.push_back('{pc: pend_addr, ins: rd});
        exp_addr = pend_addr + 32'd4;
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    inst_mem_resp = 1'b0; inst_mem_rdata = '0;
    force_redir = 1'b0; force_rpc = '0;
    p_stall = 0; p_redir = 0; lat_max = 1;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instruction, 32'd0);
    check("rst_read", 32'(inst_mem_read), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("first_addr", inst_mem_address, 32'h0000_0060);

    repeat (12) run_cycle();

    force_rpc = 32'h0000_0203; force_redir = 1'b1;
    repeat (10) run_cycle();

    force_rpc = 32'hFFFF_FFFC; force_redir = 1'b1;
    repeat (10) run_cycle();

    p_stall = 30; p_redir = 5; lat_max = 3;
    repeat (4000) run_cycle();
    p_stall = 60; p_redir = 15;
    repeat (2000) run_cycle();

    p_stall = 20; p_redir = 30;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!(busy && pend_stale) && n < 2000);
    check("discard_reached", 32'(busy && pend_stale), 32'd1);

    @(negedge clk);
    stall = 1'b0; redirect = 1'b0; inst_mem_resp = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_pc", if_pc, 32'd0);
    check("mid_rst_instr", if_instruction, 32'd0);
    check("mid_rst_read", 32'(inst_mem_read), 32'd0);
    check("mid_rst_skid", 32'(dut.u_skid.valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_read", 32'(inst_mem_read), 32'd1);
    check("post_rst_addr", inst_mem_address, 32'h0000_0060);

    p_stall = 30; p_redir = 5;
    repeat (300) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
